ft601_rd_ctrl: RTL

- Host-to-FPGA read path for the FT601 245 synchronous FIFO bus; the receive-side counterpart of the FT601 write buffer, running on the FT601 clock.
- Takes the bus when granted and the FT601 flags data, strobes OE_N/RD_N, and captures 36-bit words (32 data + 4 byte-enable).
- Buffers words in a local FIFO and presents them downstream on a valid/ready interface.
- Hands the bus back after a bounded burst so the write path is not starved.

---
 rtl/ft601_rd_ctrl_if.sv | 27 ++
 rtl/ft601_rd_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ft601_rd_ctrl_if.sv
// FT601 read-path bundle: arbiter handshake, FT601 pads, downstream stream.
// master = environment/host side, slave = ft601_rd_ctrl.
interface ft601_rd_ctrl_if;
    logic        rd_grant;
    logic        rd_busy;
    logic        rd_done;
    logic        ft_rxf_n;
    logic [35:0] ft_data_in;
    logic        ft_oe_n;
    logic        ft_rd_n;
    logic        ft_bus_oe;
    logic [35:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output rd_grant, ft_rxf_n, ft_data_in, out_ready,
        input  rd_busy, rd_done, ft_oe_n, ft_rd_n,
        input  ft_bus_oe, out_data, out_valid
    );

    modport slave (
        input  rd_grant, ft_rxf_n, ft_data_in, out_ready,
        output rd_busy, rd_done, ft_oe_n, ft_rd_n,
        output ft_bus_oe, out_data, out_valid
    );
endinterface

// File: rtl/ft601_rd_ctrl.sv
// FT601 245-sync read controller with FWFT buffer and bounded bursts.
// Optional FT601_RD_STATS_EN adds rd_word_count / rd_overflow.
module ft601_rd_ctrl #(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4,
    parameter int MAX_BURST    = 256
) (
    input  logic rd_clk,
    input  logic rd_reset_n,
    ft601_rd_ctrl_if.slave bus
`ifdef FT601_RD_STATS_EN
    ,
    output logic [31:0] rd_word_count,
    output logic        rd_overflow
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        OE,
        READ,
        DRAIN,
        TURN
    } state_e;

    state_e        state_q, state_d;
    logic          rxf_q;
    logic [35:0]   data_q;
    logic          ft_oe_n_q, ft_oe_n_d;
    logic          ft_rd_n_q, ft_rd_n_d;
    logic          rd_n_q;
    logic          done_q, done_d;
    logic          drain_q, drain_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [35:0]   mem_q [DEPTH];

    logic          empty, full, capture, push, pop;
    logic          space_ok, limit, rd_go;
    logic [AW:0]   free_w;
    logic [BW+1:0] issued;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        free_w   = (AW+1)'(DEPTH) - count_q;
        space_ok = free_w > (AW+1)'(AFULL_MARGIN);
        capture  = !rxf_q && !rd_n_q;
        push     = capture && !full;
        pop      = !empty && bus.out_ready;
        // strobes still in the pad/input pipeline count toward the burst
        issued   = (BW+2)'(burst_q)
                 + (BW+2)'(!ft_rd_n_q)
                 + (BW+2)'(!rd_n_q);
        limit    = (MAX_BURST != 0)
                && (issued >= (BW+2)'(MAX_BURST));
        rd_go    = bus.rd_grant && !rxf_q && space_ok && !limit;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        burst_d  = burst_q + BW'(capture);
        if (state_q == TURN) begin
            burst_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        ft_oe_n_d = 1'b1;
        ft_rd_n_d = 1'b1;
        drain_d   = drain_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rd_grant && !rxf_q && space_ok) begin
                    state_d   = OE;
                    ft_oe_n_d = 1'b0;
                end
            end
            OE: begin
                ft_oe_n_d = 1'b0;
                drain_d   = 1'b0;
                if (!bus.rd_grant) begin
                    state_d = DRAIN;
                end else begin
                    state_d   = READ;
                    ft_rd_n_d = !rd_go;
                end
            end
            READ: begin
                ft_oe_n_d = 1'b0;
                drain_d   = 1'b0;
                if (rd_go) begin
                    ft_rd_n_d = 1'b0;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                ft_oe_n_d = 1'b0;
                drain_d   = 1'b1;
                if (drain_q) begin
                    state_d   = TURN;
                    ft_oe_n_d = 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            state_q   <= IDLE;
            rxf_q     <= 1'b1;
            data_q    <= '0;
            ft_oe_n_q <= 1'b1;
            ft_rd_n_q <= 1'b1;
            rd_n_q    <= 1'b1;
            done_q    <= 1'b0;
            drain_q   <= 1'b0;
            burst_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rxf_q     <= bus.ft_rxf_n;
            data_q    <= bus.ft_data_in;
            ft_oe_n_q <= ft_oe_n_d;
            ft_rd_n_q <= ft_rd_n_d;
            rd_n_q    <= ft_rd_n_q;
            done_q    <= done_d;
            drain_q   <= drain_d;
            burst_q   <= burst_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_q;
        end
    end

`ifdef FT601_RD_STATS_EN
    logic [31:0] wc_q, wc_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        wc_d  = wc_q + 32'(capture);
        ovf_d = ovf_q | (capture && full);
    end

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            wc_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wc_q  <= wc_d;
            ovf_q <= ovf_d;
        end
    end

    assign rd_word_count = wc_q;
    assign rd_overflow   = ovf_q;
`endif

    assign bus.ft_oe_n   = ft_oe_n_q;
    assign bus.ft_rd_n   = ft_rd_n_q;
    assign bus.ft_bus_oe = (state_q == IDLE);
    assign bus.rd_busy   = (state_q != IDLE);
    assign bus.rd_done   = done_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
endmodule
